// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_e    5-bit operation code (11 base ops + 8 RV32M ops)
//   state_e     handshake FSM state of alu_pipe
//   is_muldiv() true for codes handled by the iterative unit
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b0_0000,
        OP_SUB    = 5'b0_0001,
        OP_AND    = 5'b0_0010,
        OP_OR     = 5'b0_0011,
        OP_XOR    = 5'b0_0100,
        OP_SLL    = 5'b0_0101,
        OP_SRL    = 5'b0_0110,
        OP_SRA    = 5'b0_0111,
        OP_SLT    = 5'b0_1000,
        OP_SLTU   = 5'b0_1001,
        OP_PASSB  = 5'b0_1111,
        OP_MUL    = 5'b1_0000,
        OP_MULH   = 5'b1_0001,
        OP_MULHSU = 5'b1_0010,
        OP_MULHU  = 5'b1_0011,
        OP_DIV    = 5'b1_0100,
        OP_DIVU   = 5'b1_0101,
        OP_REM    = 5'b1_0110,
        OP_REMU   = 5'b1_0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // All multiply/divide codes live in 1_0xxx.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared radix-2 iterative multiply/divide unit.
//   clk, rst_n  clock, async active-low reset
//   start       load operands (one-cycle pulse, unit must be idle)
//   op          M-group operation, sampled with start
//   a, b        operands, sampled with start
//   done        high for one cycle; result is valid during that cycle
//   result      sign-corrected result (combinational from internal state)
// Timing: start at edge E0, WIDTH steps at E1..E_WIDTH, done is high in the
// cycle ending at E_(WIDTH+1), where the consumer latches result.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   md;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw;    // original dividend for divide-by-zero remainder
    logic [SHW-1:0]     cnt;
    logic               busy;
    logic               fix;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    alu_op_e            op_q;

    // Operand sign handling at start
    logic             signed_a;
    logic             signed_b;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OP_MULHSU: signed_a = 1'b1;
            default: ;
        endcase
        sign_a = signed_a & a[WIDTH-1];
        sign_b = signed_b & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // One multiply step: conditional add of the multiplicand into the high
    // half, then shift the whole accumulator right (carry enters the top).
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // One restoring-divide step: shift {rem, q} left, trial-subtract divisor.
    logic [WIDTH:0]     r_sh;
    logic [WIDTH+1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, md} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        r_sh     = acc[2*WIDTH-1:WIDTH-1];
        diff     = {1'b0, r_sh} - {2'b00, md};
        ge       = ~diff[WIDTH+1];
        div_next = {(ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            md     <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            fix    <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            op_q   <= OP_MUL;
        end else if (start) begin
            op_q   <= op;
            is_div <= op[2];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            dz     <= (b == '0);
            a_raw  <= a;
            cnt    <= SHW'(WIDTH - 1);
            busy   <= 1'b1;
            fix    <= 1'b0;
            if (op[2]) begin
                acc <= {{WIDTH{1'b0}}, mag_a};
                md  <= mag_b;
            end else begin
                acc <= {{WIDTH{1'b0}}, mag_b};
                md  <= mag_a;
            end
        end else if (busy) begin
            if (fix) begin
                busy <= 1'b0;
                fix  <= 1'b0;
            end else begin
                acc <= is_div ? div_next : mul_next;
                if (cnt == '0)
                    fix <= 1'b1;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

    // Sign correction and divide-by-zero override, applied in the cycle the
    // consumer latches the result.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        prod  = neg_q ? -acc : acc;
        quot  = acc[WIDTH-1:0];
        rem   = acc[2*WIDTH-1:WIDTH];
        q_fix = dz ? '1    : (neg_q ? -quot : quot);
        r_fix = dz ? a_raw : (neg_r ? -rem  : rem);
        case (op_q)
            OP_MUL:                       result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              result = q_fix;
            OP_REM, OP_REMU:              result = r_fix;
            default:                      result = '0;
        endcase
    end

    assign done = fix;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and an iterative
// RV32M multiply/divide unit.
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (SrcA, SrcB, ALUControl)
//   out_valid / out_ready result handshake (ALUResult, Zero)
//   ALUResult             registered result, held while stalled
//   Zero                  registered flag, ALUResult == 0
// Base ops: latency 1, full throughput. M ops: latency WIDTH+1.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [4:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    state_e           state;
    alu_op_e          op;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] base_result;
    logic [SHW-1:0]   shamt;

    assign op        = alu_op_e'(ALUControl);
    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign md_start  = accept & is_muldiv(ALUControl);
    assign shamt     = SrcB[SHW-1:0];

    always_comb begin
        case (op)
            OP_ADD:   base_result = SrcA + SrcB;
            OP_SUB:   base_result = SrcA - SrcB;
            OP_AND:   base_result = SrcA & SrcB;
            OP_OR:    base_result = SrcA | SrcB;
            OP_XOR:   base_result = SrcA ^ SrcB;
            OP_SLL:   base_result = SrcA << shamt;
            OP_SRL:   base_result = SrcA >> shamt;
            OP_SRA:   base_result = unsigned'($signed(SrcA) >>> shamt);
            OP_SLT:   base_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU:  base_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_PASSB: base_result = SrcB;
            default:  base_result = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (op),
        .a      (SrcA),
        .b      (SrcB),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_muldiv(ALUControl)) begin
                            state <= ST_BUSY;
                        end else begin
                            state     <= ST_DONE;
                            ALUResult <= base_result;
                            Zero      <= (base_result == '0);
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state     <= ST_DONE;
                        ALUResult <= md_result;
                        Zero      <= (md_result == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32 and WIDTH=16.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] src_a, src_b, alu_result;
    logic [4:0]  alu_ctl;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_zero;
    logic [15:0] h_src_a, h_src_b, h_result;
    logic [4:0]  h_ctl;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(src_a), .SrcB(src_b), .ALUControl(alu_ctl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(alu_result), .Zero(zero)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .SrcA(h_src_a), .SrcB(h_src_b), .ALUControl(h_ctl),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .ALUResult(h_result), .Zero(h_zero)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one op; returns #1 after the accepting edge with in_valid dropped.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready", {31'b0, in_ready}, 32'd1);
        alu_ctl  = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted after the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        issue(op, a, b);
        wait_result(lat);
        check(tag, alu_result, exp);
    endtask

    initial begin
        int lat;
        int stale;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        src_a = '0; src_b = '0; alu_ctl = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1;
        h_src_a = '0; h_src_b = '0; h_ctl = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back base ops
        alu_ctl = OP_ADD; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        check("add_result", alu_result, 32'd12);
        check("add_zero", {31'b0, zero}, 32'd0);
        check("add_in_ready", {31'b0, in_ready}, 32'd1);
        alu_ctl = OP_SUB; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sub_result", alu_result, 32'd0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        check("sub_out_valid", {31'b0, out_valid}, 32'd1);
        check("sub_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Multiply group
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000);
        check("mulh_busy_in_ready", {31'b0, in_ready}, 32'd0);
        wait_result(lat);
        check("mulh_latency", lat, 32'd33);
        check("mulh", alu_result, 32'h4000_0000);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);

        // Divide corners
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_by0", OP_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", OP_REMU, 32'd10, 32'd0, 32'd10);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        check("rem_ovf_zero", {31'b0, zero}, 32'd1);
        issue(OP_DIV, 32'd9, 32'd0);
        wait_result(lat);
        check("div_by0_latency", lat, 32'd33);
        check("div_by0", alu_result, 32'hFFFF_FFFF);

        // Reset in the middle of a multiply
        run_op("pre_rst_add", OP_ADD, 32'd5, 32'd7, 32'd12);
        issue(OP_MUL, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", alu_result, 32'd0);
        check("midrst_zero", {31'b0, zero}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 32'd0);

        // Backpressure with a queued shift
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_result(lat);
        check("divu_bp", alu_result, 32'd14);
        alu_ctl = OP_SLL; src_a = 32'd1; src_b = 32'd35; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_result", alu_result, 32'd14);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sll_masked", alu_result, 32'd8);
        check("sll_out_valid", {31'b0, out_valid}, 32'd1);

        // 16-bit instance
        h_ctl = OP_MULHU; h_src_a = 16'hFFFF; h_src_b = 16'hFFFF; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_mulhu_latency", lat, 32'd17);
        check("w16_mulhu", {16'b0, h_result}, 32'h0000_FFFE);
        h_ctl = OP_SRA; h_src_a = 16'h8000; h_src_b = 16'd4; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        check("w16_sra", {16'b0, h_result}, 32'h0000_F800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational integer ALU, adding the RV32M multiply/divide group. Base operations complete in one cycle; multiply and divide run on an iterative unit over WIDTH cycles. Operands enter and results leave through valid/ready handshakes, so the execute stage stalls on multi-cycle operations instead of widening the critical path.

## Interface
- WIDTH, 32: operand/result width (≥8, power of two)
- SHW, $clog2(WIDTH): shift-amount bits (derived, do not override)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B
- ALUControl  in  5  operation (alu_pkg::alu_op_e)
- out_valid  out  1  Result/Zero valid
- out_ready  in  1  consumer takes result
- ALUResult  out  WIDTH  registered result
- Zero  out  1  ALUResult == 0

## Operation
- Opcodes 0_0000–0_1001 and 0_1111 keep existing base semantics (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, pass-SrcB). Shifts use SrcB[SHW-1:0]. Other undefined codes give result 0.
- New codes: 1_0000 MUL (low WIDTH), 1_0001 MULH (s×s high), 1_0010 MULHSU (s×u high), 1_0011 MULHU (u×u high), 1_0100 DIV, 1_0101 DIVU, 1_0110 REM, 1_0111 REMU.
- FSM: IDLE, BUSY, DONE.
  - IDLE: on in_valid, a base op goes to DONE with its result latched; a M op latches operands, goes to BUSY, and sets the counter to WIDTH-1.
  - BUSY: one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide). At counter 0, the next edge applies sign correction, latches the result, and goes to DONE.
  - DONE: out_valid=1. On out_ready, return to IDLE. If in_valid is also high, accept the new op in the same cycle, with the same rules as IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Signed multiply and divide operate on magnitudes; the sign is restored in the correction cycle.
- Divide by zero: quotient = all ones, remainder = SrcA. No exception.
- Overflow (DIV/REM with SrcA = most-negative value, SrcB = -1): quotient = SrcA, remainder = 0.
- Divide by zero and overflow still take the full iterative latency (constant-time).
- ALUResult and Zero hold stable while out_valid & !out_ready.

## Timing
- Reset (async assert, sync release): state=IDLE, out_valid=0, ALUResult=0, Zero=1, counter=0, in_ready=1 after release. Reset mid-BUSY aborts the operation; no result is produced.
- Base op: accepted at edge E0, out_valid high from E0 onward. Latency 1, throughput 1/cycle with out_ready held high.
- M op: accepted at E0, iterations at E1..E_WIDTH, result at E_(WIDTH+1). Latency WIDTH+1 (33 at default). in_ready=0 throughout BUSY.
- in_valid during BUSY is ignored; the source must hold its request.
- Zero is registered together with ALUResult, never computed combinationally from the output.

## Structure
- Package alu_pkg holds:
  - alu_op_e, the 5-bit enum of all 19 codes
  - is_muldiv(op) function
  - the FSM state enum
- Sub-module alu_muldiv_iter holds the shared iterative datapath: 2·WIDTH accumulator, counter, sign flags, correction logic. It has start/done pins and is instantiated once.
- Top-level alu_pipe holds the base-op combinational path, the FSM, and the output registers.

## Test plan
- Reset mid-BUSY: assert rst_n=0 after MUL starts → next cycle out_valid=0, ALUResult=0, Zero=1; after release in_ready=1 and no stale result appears.
- ADD back-to-back: 5+7 then 3-3 (SUB), out_ready=1 → results 12 then 0 on consecutive cycles, Zero=0 then 1, in_ready never low.
- MULH: 0x8000_0000 × 0x8000_0000 → 0x4000_0000 after exactly 33 cycles; MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF; MUL 7×-3 → 0xFFFF_FFEB.
- Divide corners: DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 10/0 → 0xFFFF_FFFF; REMU 10/0 → 10; DIV 0x8000_0000/-1 → 0x8000_0000; REM of same → 0.
- Backpressure: DIVU 100/7 done, out_ready held 0 for 5 cycles → ALUResult stays 14, in_ready=0; out_ready=1 with a queued SLL 1<<35 → next result 8 (shift masked to 3).
- WIDTH=16 instance: MULHU 0xFFFF×0xFFFF → 0xFFFE after 17 cycles; SRA 0x8000 by 4 → 0xF800.
